ahb_frame_mapper: RTL

Parametrised serial-frame-to-AHB mapper. It deserialises bit-strobed serial data from the SPI slave into one AHB-side transaction word: prdata, haddr, hwdata, htrans, hreadyin and hwrite. It sits between the SPI slave and the AHB-APB bridge input. Compared with the fixed 100-bit mapper it adds:
- explicit framing;
- per-bit valid qualification;
- optional even-parity checking;
- a valid/ready output handshake with overrun detection;
- field widths set by parameters.

---
 rtl/ahb_frame_mapper.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ahb_frame_mapper.sv
// Deserialises an MSB-first, bit-strobed SPI frame into one AHB-side transaction word,
// presented through a single-entry valid/ready slot with optional even-parity checking.
module ahb_frame_mapper #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              serial_in,
  input  logic              out_ready,
  output logic              frame_valid,
  output logic [DATA_W-1:0] prdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  output logic [1:0]        htrans,
  output logic              hreadyin,
  output logic              hwrite,
  output logic              parity_err,
  output logic              overrun,
  output logic              frame_abort
);

  localparam int PAY_W   = 2*DATA_W + ADDR_W + 4;
  localparam int FRAME_W = PAY_W + PARITY_EN;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int HA_LSB  = DATA_W;
  localparam int HW_LSB  = DATA_W + ADDR_W;
  localparam int HT_LSB  = 2*DATA_W + ADDR_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  function automatic logic fold_parity(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  state_t             state_r;
  logic [PAY_W-1:0]   shift_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               par_r;

  logic               in_shift_s;
  logic               take_s;
  logic               last_s;
  logic               can_load_s;
  logic [CNT_W-1:0]   cnt_base_s;
  logic               par_base_s;
  logic [PAY_W-1:0]   shift_base_s;
  logic [PAY_W-1:0]   shift_next_s;
  logic [PAY_W-1:0]   payload_s;

  // Bit acceptance, frame-completion detect and payload selection for this cycle
  always_comb begin
    in_shift_s   = (state_r == SHIFT);
    take_s       = bit_valid & (frame_start | in_shift_s);
    // A frame_start restarts the frame, so a same-cycle bit becomes bit 0
    cnt_base_s   = frame_start ? {CNT_W{1'b0}} : cnt_r;
    par_base_s   = frame_start ? 1'b0 : par_r;
    shift_base_s = frame_start ? {PAY_W{1'b0}} : shift_r;
    shift_next_s = {shift_base_s[PAY_W-2:0], serial_in};
    last_s       = take_s & (cnt_base_s == LAST_CNT);
    // With parity the final bit is the parity bit, so the payload is already complete
    payload_s    = (PARITY_EN != 0) ? shift_base_s : shift_next_s;
    can_load_s   = ~frame_valid | out_ready;
  end

  // Framing FSM, shift/count/parity datapath and registered output slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      shift_r     <= {PAY_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      par_r       <= 1'b0;
      frame_valid <= 1'b0;
      prdata      <= {DATA_W{1'b0}};
      haddr       <= {ADDR_W{1'b0}};
      hwdata      <= {DATA_W{1'b0}};
      htrans      <= 2'b00;
      hreadyin    <= 1'b0;
      hwrite      <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      frame_abort <= frame_start & in_shift_s;

      if (take_s) begin
        shift_r <= shift_next_s;
        cnt_r   <= cnt_base_s + CNT_W'(1);
        par_r   <= fold_parity(par_base_s, serial_in);
      end else if (frame_start) begin
        shift_r <= {PAY_W{1'b0}};
        cnt_r   <= {CNT_W{1'b0}};
        par_r   <= 1'b0;
      end

      if (last_s) begin
        state_r <= IDLE;
      end else if (frame_start) begin
        state_r <= SHIFT;
      end

      if (last_s && can_load_s) begin
        frame_valid <= 1'b1;
        prdata      <= payload_s[DATA_W-1:0];
        haddr       <= payload_s[HA_LSB +: ADDR_W];
        hwdata      <= payload_s[HW_LSB +: DATA_W];
        htrans      <= payload_s[HT_LSB +: 2];
        hreadyin    <= payload_s[PAY_W-2];
        hwrite      <= payload_s[PAY_W-1];
        parity_err  <= (PARITY_EN != 0) ? fold_parity(par_base_s, serial_in) : 1'b0;
      end else if (last_s) begin
        overrun <= 1'b1;
      end else if (frame_valid && out_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
